// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared constants and helpers for the serial adder sequencer
//
// Purpose : FSM state encoding and the bit-counter width helper used by
//           serial_add_sequencer.
// Ports   : none (package).

package serial_add_pkg;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] SHIFT = 2'b01;
    localparam logic [1:0] DONE  = 2'b10;

    // Counter must index bit positions 0..WIDTH-1; a 1-bit operand still
    // needs a 1-bit counter so the vector is never zero width.
    function automatic int cnt_width(input int width);
        if (width <= 1) begin
            return 1;
        end
        return $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder.sv
// rtl/full_adder.sv - 1-bit full-adder cell
//
// Purpose : combinational single-bit slice shared by the serial sequencer.
// Ports   : a, b, cin  - addend bits and carry-in
//           sum, carry - sum bit and carry-out

module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b ^ cin;
    assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_sequencer.sv
// rtl/serial_add_sequencer.sv - bit-serial adder controller around one full-adder cell
//
// Purpose : adds two WIDTH-bit operands plus carry-in, LSB first, one bit per
//           clock through a single full_adder, and presents a registered
//           result with a one-cycle done pulse.
// Ports   : clk, rst      - clock, asynchronous active-high reset
//           start         - request, sampled only when busy is low
//           a, b, cin     - operands and carry-in, captured at accepted start
//           busy          - operation in progress
//           done          - one-cycle pulse when sum/cout update
//           sum, cout     - result of the last completed operation
//           ovf           - signed overflow (only with SERIAL_ADD_OVF_EN)
// Config  : define SERIAL_ADD_OVF_EN to add the ovf output and its logic.

module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_sum;
    logic             fa_carry;
    logic             last_step;

    full_adder u_fa (
        .a     (a_sh[0]),
        .b     (b_sh[0]),
        .cin   (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

    // New sum bit enters at the MSB so after WIDTH steps the first bit
    // computed has walked down to bit 0.
    generate
        if (WIDTH == 1) begin : g_res_w1
            assign res_next = fa_sum;
        end else begin : g_res_wn
            assign res_next = {fa_sum, res[WIDTH-1:1]};
        end
    endgenerate

    assign last_step = (cnt == LAST);

    // Decoded from state so an asynchronous reset drops busy immediately.
    assign busy = (state == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                SHIFT: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    res   <= res_next;
                    carry <= fa_carry;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        sum   <= res_next;
                        cout  <= fa_carry;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                // IDLE and DONE both accept a new request; DONE accepting
                // gives back-to-back operation with no idle gap.
                default: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        res   <= '0;
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef SERIAL_ADD_OVF_EN
    // On the final step the carry register holds the carry into the MSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (state == SHIFT && last_step) begin
            ovf <= carry ^ fa_carry;
        end
    end
`endif

endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb/tb_serial_add_sequencer.sv - self-checking bench for serial_add_sequencer

module tb_serial_add_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;
`ifdef SERIAL_ADD_OVF_EN
    logic       ovf;
    logic       ovf1;
`endif

    int checks = 0;
    int errors = 0;

    // {ovf, cout, sum}
    logic [9:0] sb[$];
    logic [2:0] sb1[$];

    always #5 clk = ~clk;

    serial_add_sequencer #(.WIDTH(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    serial_add_sequencer #(.WIDTH(1)) dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
`ifdef SERIAL_ADD_OVF_EN
        ,
        .ovf   (ovf1)
`endif
    );

    function automatic logic [9:0] calc_exp(input logic [7:0] xa, input logic [7:0] xb,
                                            input logic xc);
        logic [8:0] t;
        logic       v;
        t = {1'b0, xa} + {1'b0, xb} + {8'd0, xc};
        v = (xa[7] == xb[7]) && (t[7] != xa[7]);
        return {v, t};
    endfunction

    // One-cycle start pulse; returns at the negedge just after the accept edge.
    task automatic drive_start(input logic [7:0] xa, input logic [7:0] xb, input logic xc);
        @(negedge clk);
        a     = xa;
        b     = xb;
        cin   = xc;
        start = 1'b1;
        sb.push_back(calc_exp(xa, xb, xc));
        @(negedge clk);
        start = 1'b0;
    endtask

    // Bounded wait for done; n = negedges elapsed, bcnt = samples with busy high.
    task automatic wait_done(output int n, output int bcnt);
        n    = 0;
        bcnt = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        start  = 1'b0;
        a      = '0;
        b      = '0;
        cin    = 1'b0;
        start1 = 1'b0;
        a1     = '0;
        b1     = '0;
        cin1   = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b, want all 0",
                     busy, done, sum, cout);
        end
        checks++;
        if ({busy1, done1, sum1, cout1} !== 4'd0) begin
            errors++;
            $display("FAIL reset_outputs_w1: got busy=%b done=%b sum=%b cout=%b, want all 0",
                     busy1, done1, sum1, cout1);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset_ovf: got %b want 0", ovf);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_arith;
        logic [7:0] ta[5] = '{8'h5A, 8'hFF, 8'h7F, 8'h80, 8'hC3};
        logic [7:0] tb[5] = '{8'h33, 8'h01, 8'h01, 8'h80, 8'h3C};
        logic       tc[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [9:0] exp;
        int         n;
        int         bcnt;
        for (int i = 0; i < 5; i++) begin
            drive_start(ta[i], tb[i], tc[i]);
            wait_done(n, bcnt);
            checks++;
            if (n != 8) begin
                errors++;
                $display("FAIL arith_latency[%0d]: got %0d cycles want 8", i, n);
            end
            checks++;
            if (bcnt != 8 || busy !== 1'b0) begin
                errors++;
                $display("FAIL arith_busy[%0d]: got busy cycles=%0d busy_at_done=%b want 8/0",
                         i, bcnt, busy);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL arith_sb_empty[%0d]: got empty queue want 1 entry", i);
            end else begin
                exp = sb.pop_front();
                checks++;
                if ({cout, sum} !== exp[8:0]) begin
                    errors++;
                    $display("FAIL arith_result[%0d]: got cout=%b sum=%h want cout=%b sum=%h",
                             i, cout, sum, exp[8], exp[7:0]);
                end
`ifdef SERIAL_ADD_OVF_EN
                checks++;
                if (ovf !== exp[9]) begin
                    errors++;
                    $display("FAIL arith_ovf[%0d]: got %b want %b", i, ovf, exp[9]);
                end
`endif
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL arith_done_width[%0d]: got done=%b want 0", i, done);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [9:0] exp;
        int         first;
        int         ndone;
        first = -1;
        ndone = 0;
        @(negedge clk);
        a     = 8'h12;
        b     = 8'h34;
        cin   = 1'b0;
        start = 1'b1;
        sb.push_back(calc_exp(8'h12, 8'h34, 1'b0));
        @(negedge clk);
        a = 8'h11;
        b = 8'h22;
        sb.push_back(calc_exp(8'h11, 8'h22, 1'b0));
        for (int n = 1; n <= 22; n++) begin
            @(negedge clk);
            if (first >= 0 && n == first + 1) start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                checks++;
                if ((ndone == 1 && n != 8) || (ndone == 2 && n != 17)) begin
                    errors++;
                    $display("FAIL b2b_done_time[%0d]: got cycle %0d want %0d",
                             ndone, n, (ndone == 1) ? 8 : 17);
                end
                if (first < 0) first = n;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b2b_sb_empty: got empty queue want entry");
                end else begin
                    exp = sb.pop_front();
                    checks++;
                    if ({cout, sum} !== exp[8:0]) begin
                        errors++;
                        $display("FAIL b2b_result[%0d]: got cout=%b sum=%h want cout=%b sum=%h",
                                 ndone, cout, sum, exp[8], exp[7:0]);
                    end
                end
            end
        end
        start = 1'b0;
        checks++;
        if (ndone != 2) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d want 2", ndone);
        end
    endtask

    task automatic test_hold;
        logic [7:0] prev;
        logic [9:0] exp;
        int         n;
        int         held_bad;
        prev     = sum;
        held_bad = 0;
        drive_start(8'h00, 8'h00, 1'b1);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (sum !== prev) held_bad++;
            @(negedge clk);
            n++;
        end
        checks++;
        if (held_bad != 0 || n != 8) begin
            errors++;
            $display("FAIL hold_prev_sum: got %0d changed samples, %0d cycles want 0, 8",
                     held_bad, n);
        end
        exp = sb.pop_front();
        checks++;
        if ({cout, sum} !== exp[8:0]) begin
            errors++;
            $display("FAIL hold_result: got cout=%b sum=%h want cout=%b sum=%h",
                     cout, sum, exp[8], exp[7:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op;
        logic [9:0] exp;
        int         n;
        int         bcnt;
        int         ndone;
        drive_start(8'h9C, 8'h4D, 1'b0);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL rst_mid_op: got busy=%b done=%b sum=%h cout=%b want all 0",
                     busy, done, sum, cout);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_ovf: got %b want 0", ovf);
        end
`endif
        sb.delete();
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            errors++;
            $display("FAIL rst_no_done: got %0d done pulses want 0", ndone);
        end
        drive_start(8'h9C, 8'h4D, 1'b1);
        wait_done(n, bcnt);
        exp = sb.pop_front();
        checks++;
        if (n != 8 || {cout, sum} !== exp[8:0]) begin
            errors++;
            $display("FAIL rst_recover: got n=%0d cout=%b sum=%h want n=8 cout=%b sum=%h",
                     n, cout, sum, exp[8], exp[7:0]);
        end
        @(negedge clk);
    endtask

    task automatic test_width1;
        logic [2:0] exp;
        int         n;
        @(negedge clk);
        a1     = 1'b1;
        b1     = 1'b1;
        cin1   = 1'b1;
        start1 = 1'b1;
        // 1+1+1 = 3: sum=1 cout=1; carry into bit 0 equals cout so no overflow.
        sb1.push_back(3'b011);
        @(negedge clk);
        start1 = 1'b0;
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL w1_busy: got %b want 1", busy1);
        end
        n = 0;
        while (done1 !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        exp = sb1.pop_front();
        checks++;
        if (n != 1 || {cout1, sum1} !== exp[1:0]) begin
            errors++;
            $display("FAIL w1_result: got n=%0d cout=%b sum=%b want n=1 cout=%b sum=%b",
                     n, cout1, sum1, exp[1], exp[0]);
        end
`ifdef SERIAL_ADD_OVF_EN
        checks++;
        if (ovf1 !== exp[2]) begin
            errors++;
            $display("FAIL w1_ovf: got %b want %b", ovf1, exp[2]);
        end
`endif
        @(negedge clk);
        checks++;
        if (done1 !== 1'b0) begin
            errors++;
            $display("FAIL w1_done_width: got %b want 0", done1);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_back_to_back();
        test_hold();
        test_reset_mid_op();
        test_width1();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
